int_seq_ctrl: RTL

//  Interrupt-entry sequencer for the decode stage. Accepts an external interrupt, freezes control

---
 rtl/int_seq_ctrl_if.sv | 26 ++
 rtl/int_seq_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/int_seq_ctrl_if.sv
// Decode-side bundle between the interrupt-entry sequencer and the pipeline/control unit.
// master = pipeline side driving requests; slave = sequencer driving freeze/push/vector controls.
interface int_seq_ctrl_if;
  logic        int_req;
  logic        rti;
  logic        load_use;
  logic [31:0] pc_in;
  logic [2:0]  ccr;
  logic        freeze_cu;
  logic        stack_push;
  logic [15:0] push_data;
  logic        pc_load;
  logic [31:0] pc_vec;
  logic        int_ack;
  logic        busy;

  modport master (
    output int_req, rti, load_use, pc_in, ccr,
    input  freeze_cu, stack_push, push_data, pc_load, pc_vec, int_ack, busy
  );

  modport slave (
    input  int_req, rti, load_use, pc_in, ccr,
    output freeze_cu, stack_push, push_data, pc_load, pc_vec, int_ack, busy
  );
endinterface

// File: rtl/int_seq_ctrl.sv
// Interrupt-entry sequencer: freeze CU, drain pipeline, push return PC (hi, lo) and CCR,
// then load the vector PC. New interrupts are held pending until the ISR ends with rti.
module int_seq_ctrl #(
  parameter int          DRAIN_CYCLES = 3,
  parameter int          CNT_W        = 2,
  parameter logic [31:0] VEC_ADDR     = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  int_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    PUSH_HI,
    PUSH_LO,
    PUSH_CCR,
    VECTOR
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [31:0]      ret_pc_reg, ret_pc_next;
  logic             pending_reg, pending_next;
  logic             in_isr_reg, in_isr_next;

  logic             freeze_cu;
  logic             stack_push;
  logic [15:0]      push_data;
  logic             pc_load;
  logic             int_ack;
  logic             advance;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      ret_pc_reg  <= '0;
      pending_reg <= 1'b0;
      in_isr_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      ret_pc_reg  <= ret_pc_next;
      pending_reg <= pending_next;
      in_isr_reg  <= in_isr_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    ret_pc_next  = ret_pc_reg;
    pending_next = pending_reg | bus.int_req;
    freeze_cu    = 1'b0;
    stack_push   = 1'b0;
    push_data    = 16'h0000;
    pc_load      = 1'b0;
    int_ack      = 1'b0;
    // A load-use stall freezes the sequence and suppresses its one-shot strobes.
    advance      = !bus.load_use;

    // rti wins over the set on VECTOR exit; IDLE sees the post-rti value.
    if (bus.rti) begin
      in_isr_next = 1'b0;
    end else if (state_reg == VECTOR && advance) begin
      in_isr_next = 1'b1;
    end else begin
      in_isr_next = in_isr_reg;
    end

    case (state_reg)
      IDLE: begin
        if ((bus.int_req || pending_reg) && !in_isr_next && advance) begin
          state_next   = DRAIN;
          ret_pc_next  = bus.pc_in;
          cnt_next     = '0;
          pending_next = 1'b0;
        end
      end
      DRAIN: begin
        freeze_cu = 1'b1;
        if (advance) begin
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) begin
            state_next = PUSH_HI;
          end
        end
      end
      PUSH_HI: begin
        freeze_cu  = 1'b1;
        push_data  = ret_pc_reg[31:16];
        stack_push = advance;
        if (advance) state_next = PUSH_LO;
      end
      PUSH_LO: begin
        freeze_cu  = 1'b1;
        push_data  = ret_pc_reg[15:0];
        stack_push = advance;
        if (advance) state_next = PUSH_CCR;
      end
      PUSH_CCR: begin
        freeze_cu  = 1'b1;
        push_data  = {13'b0, bus.ccr};
        stack_push = advance;
        if (advance) state_next = VECTOR;
      end
      VECTOR: begin
        freeze_cu = 1'b1;
        pc_load   = advance;
        int_ack   = advance;
        if (advance) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.freeze_cu  = freeze_cu;
  assign bus.stack_push = stack_push;
  assign bus.push_data  = push_data;
  assign bus.pc_load    = pc_load;
  assign bus.int_ack    = int_ack;
  assign bus.pc_vec     = VEC_ADDR;
  assign bus.busy       = (state_reg != IDLE);

endmodule
